// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if
//   Single-beat AXI3 master bus shared by the instruction and data caches.
//   master modport: the bridge drives AR/AW/W channels and R/B readies.
//   slave modport:  memory side, drives the ready/response signals.
//   burst/lock/cache/prot are carried so the bridge can tie them constant.
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Turns the instruction- and data-cache sram-like request ports into
//   single-beat AXI3 transactions on one master port. Data has fixed priority
//   over instruction; only one transaction is ever outstanding.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   inst_* / data_* req/wr/size/addr/wdata in; rdata/addr_ok/data_ok out
//   axi             AXI3 master (cache_axi_bridge_if.master)
module cache_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  cache_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;

  state_t      state, state_next;
  logic        lat_src_data;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        aw_done, w_done;

  logic grant_data, grant_inst, grant, sel_wr;
  logic aw_fire, w_fire, wr_both, txn_done;

  // Grant only in IDLE; data wins. Gating with rst keeps handshakes quiet
  // while the bridge is being reset.
  assign grant_data = (state == IDLE) && !rst && data_req;
  assign grant_inst = (state == IDLE) && !rst && !data_req && inst_req;
  assign grant      = grant_data || grant_inst;
  assign sel_wr     = grant_data ? data_wr : inst_wr;

  // Handshakes derived from state so the FSM never reads its own outputs.
  assign aw_fire  = (state == WR) && !aw_done && axi.awready;
  assign w_fire   = (state == WR) && !w_done && axi.wready;
  assign wr_both  = (aw_done || aw_fire) && (w_done || w_fire);
  assign txn_done = !rst && (((state == RD_DATA) && axi.rvalid) ||
                             ((state == WR_RESP) && axi.bvalid));

  // State register, request latch and write-channel completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_src_data <= 1'b0;
      lat_wr       <= 1'b0;
      lat_size     <= 2'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        lat_src_data <= grant_data;
        lat_wr       <= sel_wr;
        lat_size     <= grant_data ? data_size  : inst_size;
        lat_addr     <= grant_data ? data_addr  : inst_addr;
        lat_wdata    <= grant_data ? data_wdata : inst_wdata;
      end
      // AW and W may complete in either order; flags clear once both are in.
      if ((state == WR) && !wr_both) begin
        aw_done <= aw_done || aw_fire;
        w_done  <= w_done || w_fire;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Next-state and channel valid/ready outputs.
  always_comb begin
    state_next  = state;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_next = sel_wr ? WR : RD_ADDR;
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_next = IDLE;
      end
      WR: begin
        axi.awvalid = !aw_done;
        axi.wvalid  = !w_done;
        if (wr_both) state_next = WR_RESP;
      end
      WR_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte-lane strobe from latched size and low address bits.
  always_comb begin
    case (lat_size)
      2'd0:    axi.wstrb = 4'b0001 << lat_addr[1:0];
      2'd1:    axi.wstrb = 4'b0011 << lat_addr[1:0];
      default: axi.wstrb = 4'b1111;
    endcase
  end

  assign axi.arid    = lat_src_data ? DATA_ID : INST_ID;
  assign axi.araddr  = lat_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, lat_size};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  assign axi.awid    = lat_src_data ? DATA_ID : INST_ID;
  assign axi.awaddr  = lat_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = {1'b0, lat_size};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wdata = lat_wdata;
  assign axi.wlast = 1'b1;

  assign inst_rdata   = axi.rdata;
  assign data_rdata   = axi.rdata;
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = txn_done && !lat_src_data;
  assign data_data_ok = txn_done && lat_src_data;

  // IDs and responses are irrelevant with a single outstanding transaction.
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp, lat_wr};

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Sits directly downstream of the instruction cache and the data cache.
- Converts their two sram-like miss/uncached ports into single-beat AXI3 transactions on one shared master port.
- Arbitrates between the ports with fixed priority, data over instruction.
- Allows exactly one outstanding transaction in total.
- AXI fields not listed below (burst, lock, cache, prot) are tied constant at the top level.

Parameters:
- INST_ID, 4'd0: ARID used for instruction reads.
- DATA_ID, 4'd1: ARID/AWID used for data reads and writes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  instruction-cache request, held until inst_addr_ok
- inst_wr  in  1  write flag (expected 0; honoured if 1)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data
- inst_rdata  out  32  read data, valid when inst_data_ok
- inst_addr_ok  out  1  address handshake
- inst_data_ok  out  1  one-cycle completion pulse
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same as the inst_* ports, for the data cache
- arid  out  4;  araddr  out  32;  arlen  out  8 (always 0);  arsize  out  3 (={1'b0,size});  arvalid  out  1;  arready  in  1
- rid  in  4;  rdata  in  32;  rresp  in  2 (ignored);  rlast  in  1 (ignored);  rvalid  in  1;  rready  out  1
- awid  out  4;  awaddr  out  32;  awlen  out  8 (always 0);  awsize  out  3;  awvalid  out  1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wlast  out  1 (always 1);  wvalid  out  1;  wready  in  1
- bid  in  4;  bresp  in  2 (ignored);  bvalid  in  1;  bready  out  1

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP.
- Reset: state=IDLE. arvalid, rready, awvalid, wvalid, bready, *_addr_ok and *_data_ok are all 0. The latched request registers are cleared to 0.
- Grant in IDLE:
  - If data_req=1: data_addr_ok=1 combinationally in the same cycle; inst_addr_ok=0.
  - Else if inst_req=1: inst_addr_ok=1.
  - *_addr_ok is never asserted outside IDLE.
- Latching on handshake (req & addr_ok): the granted port's wr, size, addr and wdata are latched along with the source (inst/data). Next state is WR if wr=1, else RD_ADDR.
- RD_ADDR:
  - arvalid=1; araddr, arsize and arid (INST_ID or DATA_ID) come from the latch.
  - On arready, go to RD_DATA.
  - arvalid stays asserted, with stable fields, until arready.
- RD_DATA:
  - rready=1.
  - On rvalid, pulse data_ok for exactly one cycle to the latched source only.
  - inst_rdata and data_rdata both equal rdata combinationally.
  - Go to IDLE.
- WR:
  - awvalid and wvalid asserted together; internal flags aw_done and w_done are set on their respective handshakes.
  - Each valid drops once its handshake completes.
  - When both are done (including in the same cycle), go to WR_RESP and clear the flags.
- WR_RESP: bready=1. On bvalid, pulse the source's data_ok for one cycle and go to IDLE.
- wstrb from latched size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << addr[1:0]
  - size 2: 4'b1111
- wdata is passed through unshifted; the cache already places bytes in lanes.
- Minimum read latency: addr_ok in cycle T, arvalid from T+1, data_ok no earlier than T+2.
- A new grant is possible in the cycle after data_ok (back to IDLE). data_ok and addr_ok never coincide.
- Requests held while the bridge is busy are neither dropped nor acknowledged; the requester keeps req high.
- Simultaneous inst_req and data_req: data wins; inst is served in the next IDLE.
- rid and bid are not checked: only one transaction is outstanding.
- Reset mid-transaction forces IDLE with all valids low. The abandoned AXI transaction is not completed; the slave is reset by the same rst.

Test Plan:
- inst_req=1, addr=0xBFC00000, size=2; arready=1 immediately; rvalid with rdata=0x3C080001 two cycles later -> inst_addr_ok in cycle 0; arvalid/araddr=0xBFC00000/arid=0 in cycle 1; inst_data_ok one-cycle pulse with inst_rdata=0x3C080001; data_data_ok stays 0.
- inst_req and data_req both high in the same cycle, data read at 0x80001000 -> data granted first (arid=1); inst_addr_ok only after data_data_ok, in the following IDLE cycle.
- Data byte write: addr=0x80000003, size=0, wdata=0xAB000000 -> wstrb=4'b1000, awsize=0, wlast=1; data_data_ok only after bvalid.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles with stable awaddr, WR_RESP entered only after both handshakes.
- arready held low for 5 cycles -> arvalid/araddr stable throughout, no addr_ok to either port, and the held inst_req is not acknowledged.
- rst asserted in RD_DATA -> next cycle all valids/readies 0, state IDLE, no data_ok; a fresh request after reset completes normally.
